hazard_controller: RTL and testbench



---
 rtl/hazard_controller.sv | 143 ++++++++++++++
 tb/tb_hazard_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - LEGv8 five-stage hazard, freeze, flush and forwarding controller
module hazard_controller #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
  input  logic               id_uses_rs2,
  input  logic [4:0]         ex_rd,
  input  logic [4:0]         mem_rd,
  input  logic [4:0]         wb_rd,
  input  logic               ex_reg_write,
  input  logic               mem_reg_write,
  input  logic               wb_reg_write,
  input  logic               ex_mem_read,
  input  logic [4:0]         ex_rs1,
  input  logic [4:0]         ex_rs2,
  input  logic               branch_taken,
  input  logic               mem_busy,
  output logic               pc_write,
  output logic               if_id_write,
  output logic               id_ex_bubble,
  output logic               flush_if_id,
  output logic               flush_id_ex,
  output logic               flush_ex_mem,
  output logic               ex_mem_write,
  output logic               mem_wb_write,
  output logic [1:0]         forward_a,
  output logic [1:0]         forward_b,
  output logic [COUNT_W-1:0] stall_cycles,
  output logic [COUNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_HOLD  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [4:0]         XZR     = 5'd31;
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_t state, state_next;
  logic   load_use;
  logic   lu_service;
  logic   flush_all;

  // XZR as a destination never produces a dependency.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       m_we,
    input logic [4:0] m_rd,
    input logic       w_we,
    input logic [4:0] w_rd
  );
    if (m_we && m_rd != XZR && m_rd == src)
      return 2'b10;
    else if (w_we && w_rd != XZR && w_rd == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    load_use = id_valid && ex_mem_read && ex_reg_write && ex_rd != XZR &&
               (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
    // The held cycle after a bubble must advance so the stall lasts exactly one cycle.
    lu_service = load_use && state != LU_HOLD;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= RUN;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = RUN;
    case (state)
      RUN, LU_HOLD, MEM_WAIT: begin
        if (mem_busy)
          state_next = MEM_WAIT;
        else if (branch_taken)
          state_next = RUN;
        else if (lu_service)
          state_next = LU_HOLD;
        else
          state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    flush_all    = 1'b0;
    ex_mem_write = 1'b1;
    mem_wb_write = 1'b1;
    forward_a    = fwd_sel(ex_rs1, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    forward_b    = fwd_sel(ex_rs2, mem_reg_write, mem_rd, wb_reg_write, wb_rd);
    if (rst) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
      forward_a    = 2'b00;
      forward_b    = 2'b00;
    end else if (mem_busy) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_write = 1'b0;
    end else if (branch_taken) begin
      flush_all    = 1'b1;
    end else if (lu_service) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end
  end

  assign flush_if_id  = flush_all;
  assign flush_id_ex  = flush_all;
  assign flush_ex_mem = flush_all;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_write && stall_cycles != CNT_MAX)
        stall_cycles <= stall_cycles + 1'b1;
      if (flush_all && flush_events != CNT_MAX)
        flush_events <= flush_events + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - scoreboard bench for hazard_controller
module tb_hazard_controller;

  logic clk, rst;
  logic id_valid, id_uses_rs2;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2;
  logic ex_reg_write, mem_reg_write, wb_reg_write, ex_mem_read;
  logic branch_taken, mem_busy;

  logic pc_write, if_id_write, id_ex_bubble, flush_if_id, flush_id_ex, flush_ex_mem;
  logic ex_mem_write, mem_wb_write;
  logic [1:0] forward_a, forward_b;
  logic [15:0] stall_cycles, flush_events;

  logic s_pc_write, s_if_id_write, s_id_ex_bubble, s_flush_if_id, s_flush_id_ex, s_flush_ex_mem;
  logic s_ex_mem_write, s_mem_wb_write;
  logic [1:0] s_forward_a, s_forward_b;
  logic [1:0] s_stall_cycles, s_flush_events;

  hazard_controller #(.COUNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .ex_mem_read(ex_mem_read), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_bubble(id_ex_bubble),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex), .flush_ex_mem(flush_ex_mem),
    .ex_mem_write(ex_mem_write), .mem_wb_write(mem_wb_write),
    .forward_a(forward_a), .forward_b(forward_b),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  hazard_controller #(.COUNT_W(2)) u_small (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs2(id_uses_rs2), .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
    .ex_mem_read(ex_mem_read), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .id_ex_bubble(s_id_ex_bubble),
    .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex), .flush_ex_mem(s_flush_ex_mem),
    .ex_mem_write(s_ex_mem_write), .mem_wb_write(s_mem_wb_write),
    .forward_a(s_forward_a), .forward_b(s_forward_b),
    .stall_cycles(s_stall_cycles), .flush_events(s_flush_events)
  );

  typedef struct {
    int         id;
    logic       pc, ifid, bub, fl, exm, mwb;
    logic [1:0] fa, fb;
    int         s, f;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;
  int   vec_id = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int id, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s vec=%0d actual=%0d expected=%0d", name, id, act, req);
    end
  endtask

  // Monitor: the controller presents a fresh output set every cycle; sample mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc_write", e.id, int'(pc_write), int'(e.pc));
      chk("if_id_write", e.id, int'(if_id_write), int'(e.ifid));
      chk("id_ex_bubble", e.id, int'(id_ex_bubble), int'(e.bub));
      chk("flush_if_id", e.id, int'(flush_if_id), int'(e.fl));
      chk("flush_id_ex", e.id, int'(flush_id_ex), int'(e.fl));
      chk("flush_ex_mem", e.id, int'(flush_ex_mem), int'(e.fl));
      chk("ex_mem_write", e.id, int'(ex_mem_write), int'(e.exm));
      chk("mem_wb_write", e.id, int'(mem_wb_write), int'(e.mwb));
      chk("forward_a", e.id, int'(forward_a), int'(e.fa));
      chk("forward_b", e.id, int'(forward_b), int'(e.fb));
      chk("stall_cycles", e.id, int'(stall_cycles), e.s);
      chk("flush_events", e.id, int'(flush_events), e.f);
      chk("small_ctrl", e.id,
          int'({s_pc_write, s_if_id_write, s_id_ex_bubble, s_flush_if_id, s_flush_id_ex,
                s_flush_ex_mem, s_ex_mem_write, s_mem_wb_write, s_forward_a, s_forward_b}),
          int'({e.pc, e.ifid, e.bub, e.fl, e.fl, e.fl, e.exm, e.mwb, e.fa, e.fb}));
      chk("small_stall_sat", e.id, int'(s_stall_cycles), (e.s > 3) ? 3 : e.s);
      chk("small_flush_sat", e.id, int'(s_flush_events), (e.f > 3) ? 3 : e.f);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #2;
  endtask

  task automatic clear();
    id_valid = 0; id_uses_rs2 = 0; id_rs1 = 0; id_rs2 = 0;
    ex_rd = 0; mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
    ex_reg_write = 0; mem_reg_write = 0; wb_reg_write = 0; ex_mem_read = 0;
    branch_taken = 0; mem_busy = 0;
  endtask

  task automatic set_lu5();
    id_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_rs1 = 5;
  endtask

  task automatic expect_out(input logic pc, input logic ifid, input logic bub, input logic fl,
                            input logic exm, input logic mwb, input logic [1:0] fa,
                            input logic [1:0] fb, input int s, input int f);
    exp_t r;
    r.id = vec_id; r.pc = pc; r.ifid = ifid; r.bub = bub; r.fl = fl;
    r.exm = exm; r.mwb = mwb; r.fa = fa; r.fb = fb; r.s = s; r.f = f;
    exp_q.push_back(r);
    vec_id++;
  endtask

  initial begin
    rst = 1;
    clear();
    next_cycle(); expect_out(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    next_cycle(); rst = 0; expect_out(1, 1, 0, 0, 1, 1, 2'b00, 2'b00, 0, 0);
    // load-use on rs1: one stall, then advance
    next_cycle(); set_lu5(); expect_out(0, 0, 1, 0, 1, 1, 2'b00, 2'b00, 0, 0);
    next_cycle(); expect_out(1, 1, 0, 0, 1, 1, 2'b00, 2'b00, 1, 0);
    next_cycle(); clear(); ex_rs1 = 5; wb_rd = 5; wb_reg_write = 1;
    expect_out(1, 1, 0, 0, 1, 1, 2'b01, 2'b00, 1, 0);
    // XZR never matches
    next_cycle(); clear(); set_lu5(); ex_rd = 31; id_rs1 = 31;
    mem_rd = 31; mem_reg_write = 1; ex_rs1 = 31;
    expect_out(1, 1, 0, 0, 1, 1, 2'b00, 2'b00, 1, 0);
    // forwarding priority MEM over WB
    next_cycle(); clear(); mem_rd = 7; wb_rd = 7; ex_rs2 = 7; mem_reg_write = 1; wb_reg_write = 1;
    expect_out(1, 1, 0, 0, 1, 1, 2'b00, 2'b10, 1, 0);
    next_cycle(); mem_reg_write = 0; expect_out(1, 1, 0, 0, 1, 1, 2'b00, 2'b01, 1, 0);
    // load-use through rs2, gated by id_uses_rs2
    next_cycle(); clear(); id_valid = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 9;
    id_rs1 = 3; id_rs2 = 9; id_uses_rs2 = 1;
    expect_out(0, 0, 1, 0, 1, 1, 2'b00, 2'b00, 1, 0);
    next_cycle(); expect_out(1, 1, 0, 0, 1, 1, 2'b00, 2'b00, 2, 0);
    next_cycle(); id_uses_rs2 = 0; expect_out(1, 1, 0, 0, 1, 1, 2'b00, 2'b00, 2, 0);
    // branch beats load-use
    next_cycle(); clear(); set_lu5(); branch_taken = 1;
    expect_out(1, 1, 0, 1, 1, 1, 2'b00, 2'b00, 2, 0);
    next_cycle(); clear(); expect_out(1, 1, 0, 0, 1, 1, 2'b00, 2'b00, 2, 1);
    // freeze with pending branch; forwarding still live
    for (int k = 0; k < 3; k++) begin
      next_cycle(); clear(); mem_busy = 1; branch_taken = 1; ex_rs1 = 4; mem_rd = 4; mem_reg_write = 1;
      expect_out(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 2 + k, 1);
    end
    next_cycle(); clear(); branch_taken = 1; expect_out(1, 1, 0, 1, 1, 1, 2'b00, 2'b00, 5, 1);
    next_cycle(); clear(); expect_out(1, 1, 0, 0, 1, 1, 2'b00, 2'b00, 5, 2);
    // MEM_WAIT then load-use, then async reset while in LU_HOLD
    next_cycle(); clear(); set_lu5(); mem_busy = 1; expect_out(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 5, 2);
    next_cycle(); mem_busy = 0; expect_out(0, 0, 1, 0, 1, 1, 2'b00, 2'b00, 6, 2);
    next_cycle(); rst = 1; expect_out(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
    next_cycle(); rst = 0; expect_out(0, 0, 1, 0, 1, 1, 2'b00, 2'b00, 0, 0);
    next_cycle(); clear(); expect_out(1, 1, 0, 0, 1, 1, 2'b00, 2'b00, 1, 0);
    next_cycle();
    next_cycle();
    chk("scoreboard_drained", vec_id, exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
